// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_t;

    localparam logic        RESET         = 1'b1;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory bus and fetch-to-decode handshake, bundled together.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, imem_err, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, imem_err, id_ready
    );
endinterface

// File: rtl/fetch_npc.sv
// Next-PC target select: trap > redirect > pending target > sequential.
module fetch_npc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_cur,
    input  logic        trap_valid,
    input  logic [31:0] trap_vec,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        pending_valid,
    input  logic [31:0] pending_addr,
    output logic [31:0] pc_next
);

    always_comb begin
        if (trap_valid)
            pc_next = align_pc(trap_vec);
        else if (redirect_valid)
            pc_next = align_pc(redirect_addr);
        else if (pending_valid)
            pc_next = pending_addr;
        else
            pc_next = pc_cur + PC_STEP;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller driving an external PC register.
//   state    | meaning
//   IDLE     | no request; waits for stall to drop
//   REQ      | request at pc_cur outstanding
//   HOLD     | instruction buffered for decode
//   DRAIN    | request outstanding, its data will be discarded
//   FAULT    | fetch error reported, waits for trap
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_cur,
    output logic         pc_hold,
    output logic [31:0]  pc_next,
    fetch_if.master      fif,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_addr,
    input  logic         trap_valid,
    input  logic [31:0]  trap_vec,
    output logic         fault,
    output logic [31:0]  fault_pc
);

    fetch_state_t state, state_d, go_state;
    logic         if_valid_q, fault_q;
    logic [31:0]  if_instr_q, if_pc_q, fault_pc_q, pend_q;
    logic         req, hold, capture, drop, set_fault, clr_fault, latch_pend;
    logic         redir_ok, jump;
    logic [31:0]  npc_addr;

    // A faulted fetcher only leaves through a trap.
    assign redir_ok = redirect_valid && (state != ST_FAULT);
    assign jump     = trap_valid || redir_ok;
    assign go_state = stall ? ST_IDLE : ST_REQ;

    fetch_npc u_npc (
        .pc_cur        (pc_cur),
        .trap_valid    (trap_valid),
        .trap_vec      (trap_vec),
        .redirect_valid(redir_ok),
        .redirect_addr (redirect_addr),
        .pending_valid (state == ST_DRAIN),
        .pending_addr  (pend_q),
        .pc_next       (npc_addr)
    );

    always_comb begin
        state_d    = state;
        req        = 1'b0;
        hold       = 1'b1;
        capture    = 1'b0;
        drop       = 1'b0;
        set_fault  = 1'b0;
        clr_fault  = 1'b0;
        latch_pend = 1'b0;
        case (state)
            ST_IDLE: begin
                hold    = !jump;
                state_d = go_state;
            end
            ST_REQ: begin
                req = 1'b1;
                if (jump) begin
                    if (fif.imem_ack) begin
                        hold    = 1'b0;
                        state_d = go_state;
                    end else begin
                        latch_pend = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end else if (fif.imem_ack) begin
                    if (fif.imem_err) begin
                        set_fault = 1'b1;
                        state_d   = ST_FAULT;
                    end else begin
                        hold    = 1'b0;
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (jump || fif.id_ready) begin
                    hold    = !jump;
                    drop    = 1'b1;
                    state_d = go_state;
                end
            end
            ST_DRAIN: begin
                req = 1'b1;
                if (fif.imem_ack) begin
                    hold    = 1'b0;
                    state_d = go_state;
                end else if (jump) begin
                    latch_pend = 1'b1;
                end
            end
            ST_FAULT: begin
                if (trap_valid) begin
                    hold      = 1'b0;
                    clr_fault = 1'b1;
                    state_d   = go_state;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst == RESET) begin
            req  = 1'b0;
            hold = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            state      <= ST_IDLE;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            pend_q     <= '0;
        end else begin
            state <= state_d;
            if (capture) begin
                if_valid_q <= 1'b1;
                if_instr_q <= fif.imem_rdata;
                if_pc_q    <= pc_cur;
            end else if (drop) begin
                if_valid_q <= 1'b0;
            end
            if (set_fault) begin
                fault_q    <= 1'b1;
                fault_pc_q <= pc_cur;
            end else if (clr_fault) begin
                fault_q <= 1'b0;
            end
            if (latch_pend)
                pend_q <= npc_addr;
        end
    end

    assign fif.imem_req  = req;
    assign fif.imem_addr = pc_cur;
    assign fif.if_valid  = if_valid_q;
    assign fif.if_instr  = if_instr_q;
    assign fif.if_pc     = if_pc_q;
    assign pc_hold       = hold;
    assign pc_next       = hold ? pc_cur : npc_addr;
    assign fault         = fault_q;
    assign fault_pc      = fault_pc_q;

endmodule
